accel_cmd_responder: RTL and testbench

ACCEL_CMD_RESPONDER -- requirements
Module: accel_cmd_responder

---
 rtl/accel_pkg.sv | 48 ++++
 rtl/resp_byte_mux.sv | 33 +++
 rtl/accel_cmd_responder.sv | 121 ++++++++++++
 tb/tb_accel_cmd_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg -- shared constants for the accelerometer command responder.
//
// Holds the UART command bytes, the axis codes driven on `dimension`,
// the responder FSM state encoding and the response frame length.
//
// Build option: ACCEL_RESP_CKSUM_EN -- when defined, the frame carries a
// fourth checksum byte, so FRAME_LEN becomes 4 instead of 3.

package accel_pkg;

    localparam logic [7:0] CMD_X = 8'h78;   // 'x'
    localparam logic [7:0] CMD_Y = 8'h79;   // 'y'
    localparam logic [7:0] CMD_Z = 8'h7A;   // 'z'

    localparam logic [2:0] DIM_X = 3'd0;
    localparam logic [2:0] DIM_Y = 3'd1;
    localparam logic [2:0] DIM_Z = 3'd2;

`ifdef ACCEL_RESP_CKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        LOAD      = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } respState_t;

    function automatic logic isCmd(input logic [7:0] b);
        return (b == CMD_X) || (b == CMD_Y) || (b == CMD_Z);
    endfunction

    function automatic logic [2:0] cmdToDim(input logic [7:0] b);
        case (b)
            CMD_Y:   return DIM_Y;
            CMD_Z:   return DIM_Z;
            default: return DIM_X;
        endcase
    endfunction

endpackage

// File: rtl/resp_byte_mux.sv
// resp_byte_mux -- combinational selector for the response frame byte.
//
// Ports:
//   byteIdx   in  2   position within the frame
//   sample    in  16  latched accelerometer sample
//   frameByte out 8   byte to transmit at byteIdx
//
// Frame: 0 = HEADER_BYTE, 1 = sample low byte, 2 = sample high byte.
// Build option: ACCEL_RESP_CKSUM_EN adds 3 = HEADER_BYTE ^ low ^ high.

module resp_byte_mux
    import accel_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = 8'h00
) (
    input  logic [1:0]  byteIdx,
    input  logic [15:0] sample,
    output logic [7:0]  frameByte
);

    always_comb begin
        frameByte = HEADER_BYTE;
        case (byteIdx)
            2'd1:    frameByte = sample[7:0];
            2'd2:    frameByte = sample[15:8];
`ifdef ACCEL_RESP_CKSUM_EN
            2'd3:    frameByte = HEADER_BYTE ^ sample[7:0] ^ sample[15:8];
`endif
            default: frameByte = HEADER_BYTE;
        endcase
    end

endmodule

// File: rtl/accel_cmd_responder.sv
// accel_cmd_responder -- answers single-byte UART axis commands with a
// framed accelerometer sample.
//
// A command byte 'x'/'y'/'z' selects the axis, waits SETTLE_CYCLES for the
// SPI readback to follow the new axis, latches the sample, then sends the
// frame byte by byte through the UART transmitter handshake.
//
// Ports:
//   CLK_50         in  1   system clock (50 MHz)
//   RST            in  1   asynchronous active-high reset
//   RxD_data_ready in  1   receiver strobe, RxD_data valid
//   RxD_data       in  8   received command byte
//   data           in  16  sample for the selected axis
//   TxD_busy       in  1   transmitter busy
//   dimension      out 3   axis select (0=x, 1=y, 2=z)
//   TxD_start      out 1   one-cycle transmit start
//   TxD_data       out 8   byte being transmitted
//   resp_busy      out 1   responder not idle
//   cmd_drop       out 1   command arrived while busy and was discarded
//
// Build option: ACCEL_RESP_CKSUM_EN appends a checksum byte (4-byte frame).

module accel_cmd_responder
    import accel_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter logic [7:0]  HEADER_BYTE   = 8'h00
) (
    input  logic        CLK_50,
    input  logic        RST,
    input  logic        RxD_data_ready,
    input  logic [7:0]  RxD_data,
    input  logic [15:0] data,
    input  logic        TxD_busy,
    output logic [2:0]  dimension,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    output logic        resp_busy,
    output logic        cmd_drop
);

    // 0 and 1 both collapse to a single SETTLE cycle.
    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 32'd0 : 32'(SETTLE_CYCLES - 1);

    respState_t  state, nextState;
    logic [31:0] settleCnt;
    logic [15:0] sample;
    logic [1:0]  byteIdx;
    logic [7:0]  frameByte;
    logic        validCmd;
    logic        inFrame;

    assign validCmd = RxD_data_ready && isCmd(RxD_data);

    resp_byte_mux #(
        .HEADER_BYTE (HEADER_BYTE)
    ) uByteMux (
        .byteIdx   (byteIdx),
        .sample    (sample),
        .frameByte (frameByte)
    );

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        TxD_start = 1'b0;
        case (state)
            IDLE:      if (validCmd) nextState = SETTLE;
            SETTLE:    if (settleCnt >= SETTLE_LAST) nextState = LOAD;
            LOAD:      nextState = SEND;
            SEND: begin
                if (!TxD_busy) begin
                    TxD_start = 1'b1;
                    nextState = WAIT_ACK;
                end
            end
            WAIT_ACK:  if (TxD_busy) nextState = WAIT_DONE;
            WAIT_DONE: if (!TxD_busy) nextState = (byteIdx == LAST_IDX) ? IDLE : SEND;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            dimension <= DIM_X;
            settleCnt <= '0;
            byteIdx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (validCmd) begin
                        dimension <= cmdToDim(RxD_data);
                        settleCnt <= '0;
                    end
                end
                SETTLE:    settleCnt <= settleCnt + 32'd1;
                LOAD:      byteIdx <= '0;
                WAIT_DONE: if (!TxD_busy) byteIdx <= byteIdx + 2'd1;
                default: ;
            endcase
        end
    end

    // Sample is captured only in LOAD, so every byte of a frame comes from
    // the same reading even if `data` moves during transmission.
    always_ff @(posedge CLK_50) begin
        if (state == LOAD) sample <= data;
    end

    // TxD_data is forced to zero outside the send states so reset and idle
    // present a clean bus regardless of the (unreset) sample register.
    assign inFrame   = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_DONE);
    assign TxD_data  = inFrame ? frameByte : 8'h00;
    assign resp_busy = (state != IDLE);
    assign cmd_drop  = validCmd && (state != IDLE);

endmodule

// File: tb/tb_accel_cmd_responder.sv
module tb_accel_cmd_responder;

    localparam int         SETTLE = 4;
    localparam logic [7:0] HDR    = 8'h00;
`ifdef ACCEL_RESP_CKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic        CLK_50 = 1'b0;
    logic        RST = 1'b1;
    logic        RxD_data_ready = 1'b0;
    logic [7:0]  RxD_data = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        TxD_busy = 1'b0;
    logic [2:0]  dimension;
    logic        TxD_start;
    logic [7:0]  TxD_data;
    logic        resp_busy;
    logic        cmd_drop;

    accel_cmd_responder #(
        .SETTLE_CYCLES (SETTLE),
        .HEADER_BYTE   (HDR)
    ) dut (
        .CLK_50         (CLK_50),
        .RST            (RST),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data       (RxD_data),
        .data           (data),
        .TxD_busy       (TxD_busy),
        .dimension      (dimension),
        .TxD_start      (TxD_start),
        .TxD_data       (TxD_data),
        .resp_busy      (resp_busy),
        .cmd_drop       (cmd_drop)
    );

    always #10 CLK_50 = ~CLK_50;

    int passCnt = 0;
    int failCnt = 0;
    int checkCnt = 0;

    // UART transmitter model and event recorder
    logic [7:0] txBytes[$];
    int         startEdges[$];
    int         edgeCnt = 0;
    int         strobeEdge = 0;
    int         dropCnt = 0;
    int         stableErr = 0;
    int         busyCnt = 0;
    logic [7:0] holdByte = 8'h00;

    always @(posedge CLK_50) begin
        edgeCnt <= edgeCnt + 1;
        if (RxD_data_ready) strobeEdge <= edgeCnt;
        if (cmd_drop) dropCnt <= dropCnt + 1;
        if (TxD_start) begin
            txBytes.push_back(TxD_data);
            startEdges.push_back(edgeCnt);
        end
        if (RST) begin
            TxD_busy <= 1'b0;
            busyCnt  <= 0;
        end else if (TxD_start) begin
            TxD_busy <= 1'b1;
            busyCnt  <= int'($urandom_range(1, 5));
            holdByte <= TxD_data;
        end else if (TxD_busy) begin
            if (TxD_data !== holdByte) stableErr <= stableErr + 1;
            if (busyCnt <= 1) TxD_busy <= 1'b0;
            else              busyCnt  <= busyCnt - 1;
        end
    end

    function automatic logic [7:0] expByte(input logic [15:0] s, input int i);
        case (i)
            0:       return HDR;
            1:       return s[7:0];
            2:       return s[15:8];
            default: return HDR ^ s[7:0] ^ s[15:8];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendCmd(input logic [7:0] b);
        @(negedge CLK_50);
        RxD_data_ready = 1'b1;
        RxD_data = b;
        @(negedge CLK_50);
        RxD_data_ready = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (resp_busy && n < 3000) begin
            @(negedge CLK_50);
            n++;
        end
        check({tag, "_idle"}, 32'(resp_busy), 32'd0);
    endtask

    task automatic waitBytes(input int target, input string tag);
        int n = 0;
        while (txBytes.size() < target && n < 3000) begin
            @(negedge CLK_50);
            n++;
        end
        check({tag, "_bytes_seen"}, 32'(txBytes.size() >= target), 32'd1);
    endtask

    task automatic checkFrame(input string tag, input int base, input logic [15:0] s);
        check({tag, "_len"}, 32'(txBytes.size() - base), 32'(FLEN));
        for (int i = 0; i < FLEN; i++) begin
            logic [31:0] obs;
            obs = (base + i < txBytes.size()) ? 32'(txBytes[base + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(expByte(s, i)));
        end
        check({tag, "_stable"}, 32'(stableErr), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int dropBefore;
        int n;
        logic [7:0]  cmd;
        logic [15:0] d;

        // reset state
        repeat (3) @(negedge CLK_50);
        check("rst_dimension", 32'(dimension), 32'd0);
        check("rst_txstart", 32'(TxD_start), 32'd0);
        check("rst_txdata", 32'(TxD_data), 32'd0);
        check("rst_busy", 32'(resp_busy), 32'd0);
        check("rst_drop", 32'(cmd_drop), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK_50);

        // basic 'y' frame with latency
        data = 16'hA5C3;
        base = txBytes.size();
        sendCmd(8'h79);
        check("y_dimension", 32'(dimension), 32'd1);
        check("y_busy", 32'(resp_busy), 32'd1);
        waitIdle("y");
        check("y_txbusy_at_idle", 32'(TxD_busy), 32'd0);
        checkFrame("y", base, 16'hA5C3);
        check("y_latency", 32'(startEdges[base] - strobeEdge), 32'(SETTLE + 2));

        // ignored byte
        base = txBytes.size();
        dropBefore = dropCnt;
        sendCmd(8'h41);
        check("ign_busy", 32'(resp_busy), 32'd0);
        repeat (SETTLE + 10) @(negedge CLK_50);
        check("ign_nostart", 32'(txBytes.size() - base), 32'd0);
        check("ign_nodrop", 32'(dropCnt - dropBefore), 32'd0);
        check("ign_dimension", 32'(dimension), 32'd1);

        // command dropped while sending byte 1
        d = 16'($urandom);
        data = d;
        base = txBytes.size();
        sendCmd(8'h78);
        waitBytes(base + 2, "drop");
        dropBefore = dropCnt;
        sendCmd(8'h7A);
        @(negedge CLK_50);
        check("drop_pulse_cycles", 32'(dropCnt - dropBefore), 32'd1);
        check("drop_dimension", 32'(dimension), 32'd0);
        waitIdle("drop");
        checkFrame("drop", base, d);

        // sample held although data changes after LOAD
        data = 16'h1234;
        base = txBytes.size();
        sendCmd(8'h79);
        waitBytes(base + 1, "hold");
        data = 16'hFFFF;
        waitIdle("hold");
        checkFrame("hold", base, 16'h1234);

        // reset mid-frame during WAIT_DONE of byte 1
        data = 16'hBEEF;
        base = txBytes.size();
        sendCmd(8'h7A);
        waitBytes(base + 2, "rstmid");
        @(negedge CLK_50);
        RST = 1'b1;
        #1;
        check("rstmid_dimension", 32'(dimension), 32'd0);
        check("rstmid_txstart", 32'(TxD_start), 32'd0);
        check("rstmid_txdata", 32'(TxD_data), 32'd0);
        check("rstmid_busy", 32'(resp_busy), 32'd0);
        check("rstmid_drop", 32'(cmd_drop), 32'd0);
        @(negedge CLK_50);
        RST = 1'b0;
        repeat (20) @(negedge CLK_50);
        check("rstmid_nostart", 32'(txBytes.size() - base), 32'd2);
        d = 16'($urandom);
        data = d;
        base = txBytes.size();
        sendCmd(8'h78);
        check("rstmid_new_dim", 32'(dimension), 32'd0);
        waitIdle("rstmid_new");
        checkFrame("rstmid_new", base, d);

        // checksum pattern (plain 3-byte frame when the option is off)
        data = 16'h0F0F;
        base = txBytes.size();
        sendCmd(8'h78);
        waitIdle("ck");
        checkFrame("ck", base, 16'h0F0F);

        // randomized frames
        for (int k = 0; k < 6; k++) begin
            cmd = 8'h78 + 8'($urandom_range(0, 2));
            d = 16'($urandom);
            data = d;
            base = txBytes.size();
            sendCmd(cmd);
            check($sformatf("rnd%0d_dim", k), 32'(dimension), 32'(cmd - 8'h78));
            waitIdle($sformatf("rnd%0d", k));
            checkFrame($sformatf("rnd%0d", k), base, d);
            check($sformatf("rnd%0d_latency", k), 32'(startEdges[base] - strobeEdge), 32'(SETTLE + 2));
        end

        // command coinciding with the final WAIT_DONE exit
        d = 16'($urandom);
        data = d;
        base = txBytes.size();
        sendCmd(8'h79);
        n = 0;
        while (!(txBytes.size() == base + FLEN && !TxD_busy) && n < 3000) begin
            @(negedge CLK_50);
            n++;
        end
        dropBefore = dropCnt;
        RxD_data_ready = 1'b1;
        RxD_data = 8'h78;
        #1;
        check("coin_drop", 32'(cmd_drop), 32'd1);
        @(negedge CLK_50);
        RxD_data_ready = 1'b0;
        check("coin_idle", 32'(resp_busy), 32'd0);
        check("coin_dimension", 32'(dimension), 32'd1);
        check("coin_dropcnt", 32'(dropCnt - dropBefore), 32'd1);
        checkFrame("coin", base, d);
        base2 = txBytes.size();
        repeat (SETTLE + 10) @(negedge CLK_50);
        check("coin_nostart", 32'(txBytes.size() - base2), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
